core_dma_cmd_master: RTL and testbench

//  Wrapper-side initiator for a core's DMA command port: drives dma_cmd_wr/hdr_wr, dma_cmd_rd and sinks dma_rd_resp.

---
 rtl/core_dma_cmd_master.sv | 202 ++++++++++++++++++++
 tb/tb_core_dma_cmd_master.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_dma_cmd_master.sv
// DMA command-port initiator: turns (addr,len) write/read requests into per-beat
// dma_cmd_wr / dma_cmd_rd traffic, with AXIS payload in and read data out.
module core_dma_cmd_master #(
  parameter int unsigned DATA_WIDTH     = 128,
  parameter int unsigned STRB_WIDTH     = DATA_WIDTH / 8,
  parameter int unsigned ADDR_WIDTH     = 26,
  parameter int unsigned HDR_ADDR_WIDTH = 24,
  parameter int unsigned LEN_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [ADDR_WIDTH-1:0]     wr_req_addr,
  input  logic [HDR_ADDR_WIDTH-1:0] wr_req_hdr_addr,
  input  logic                      wr_req_hdr_en,
  input  logic [LEN_WIDTH-1:0]      wr_req_len,
  input  logic                      wr_req_valid,
  output logic                      wr_req_ready,
  input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic [STRB_WIDTH-1:0]     s_axis_tkeep,
  input  logic                      s_axis_tvalid,
  input  logic                      s_axis_tlast,
  output logic                      s_axis_tready,
  output logic                      dma_cmd_wr_en,
  output logic [ADDR_WIDTH-1:0]     dma_cmd_wr_addr,
  output logic                      dma_cmd_hdr_wr_en,
  output logic [HDR_ADDR_WIDTH-1:0] dma_cmd_hdr_wr_addr,
  output logic [DATA_WIDTH-1:0]     dma_cmd_wr_data,
  output logic [STRB_WIDTH-1:0]     dma_cmd_wr_strb,
  output logic                      dma_cmd_wr_last,
  input  logic                      dma_cmd_wr_ready,
  input  logic [ADDR_WIDTH-1:0]     rd_req_addr,
  input  logic [LEN_WIDTH-1:0]      rd_req_len,
  input  logic                      rd_req_valid,
  output logic                      rd_req_ready,
  output logic                      dma_cmd_rd_en,
  output logic [ADDR_WIDTH-1:0]     dma_cmd_rd_addr,
  output logic                      dma_cmd_rd_last,
  input  logic                      dma_cmd_rd_ready,
  input  logic                      dma_rd_resp_valid,
  input  logic [DATA_WIDTH-1:0]     dma_rd_resp_data,
  output logic                      dma_rd_resp_ready,
  output logic [DATA_WIDTH-1:0]     m_axis_tdata,
  output logic [STRB_WIDTH-1:0]     m_axis_tkeep,
  output logic                      m_axis_tvalid,
  output logic                      m_axis_tlast,
  input  logic                      m_axis_tready,
  output logic                      wr_done,
  output logic                      wr_err
);
  localparam int unsigned BL = $clog2(STRB_WIDTH);
  localparam int unsigned CW = LEN_WIDTH - BL + 1;
  localparam logic [LEN_WIDTH:0] BM1 = (LEN_WIDTH+1)'(STRB_WIDTH - 1);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_DRAIN} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_CMD, R_RESP} r_state_t;

  function automatic logic [STRB_WIDTH-1:0] final_mask(input logic [BL-1:0] lo);
    final_mask = (lo == '0) ? '1 : ((STRB_WIDTH'(1) << lo) - STRB_WIDTH'(1));
  endfunction

  function automatic logic [CW-1:0] beats(input logic [LEN_WIDTH-1:0] len);
    logic [LEN_WIDTH:0] sum;
    sum   = {1'b0, len} + BM1;
    beats = CW'(sum >> BL);
  endfunction

  // ---------------- write path ----------------
  w_state_t                  w_state;
  logic [CW-1:0]             w_cnt;
  logic [BL-1:0]             w_lo;
  logic                      w_hdr_en;
  logic                      w_beat, w_final;

  assign w_final             = (w_cnt == CW'(1));
  assign dma_cmd_wr_en       = (w_state == W_DATA) && s_axis_tvalid;
  assign s_axis_tready       = ((w_state == W_DATA) && dma_cmd_wr_ready) || (w_state == W_DRAIN);
  assign w_beat              = dma_cmd_wr_en && dma_cmd_wr_ready;
  assign dma_cmd_wr_data     = s_axis_tdata;
  assign dma_cmd_wr_strb     = w_final ? (s_axis_tkeep & final_mask(w_lo)) : s_axis_tkeep;
  assign dma_cmd_wr_last     = dma_cmd_wr_en && (w_final || s_axis_tlast);
  assign dma_cmd_hdr_wr_en   = w_hdr_en && dma_cmd_wr_en;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_state             <= W_IDLE;
      wr_req_ready        <= 1'b0;
      dma_cmd_wr_addr     <= '0;
      dma_cmd_hdr_wr_addr <= '0;
      w_hdr_en            <= 1'b0;
      w_cnt               <= '0;
      w_lo                <= '0;
      wr_done             <= 1'b0;
      wr_err              <= 1'b0;
    end else begin
      wr_done <= 1'b0;
      wr_err  <= 1'b0;
      case (w_state)
        W_IDLE: begin
          wr_req_ready <= 1'b1;
          if (wr_req_valid && wr_req_ready) begin
            if (wr_req_len == '0) begin
              wr_done <= 1'b1;
            end else begin
              dma_cmd_wr_addr     <= wr_req_addr;
              dma_cmd_hdr_wr_addr <= wr_req_hdr_addr;
              w_hdr_en            <= wr_req_hdr_en;
              w_cnt               <= beats(wr_req_len);
              w_lo                <= wr_req_len[BL-1:0];
              wr_req_ready        <= 1'b0;
              w_state             <= W_DATA;
            end
          end
        end
        W_DATA: if (w_beat) begin
          dma_cmd_wr_addr     <= dma_cmd_wr_addr + ADDR_WIDTH'(STRB_WIDTH);
          dma_cmd_hdr_wr_addr <= dma_cmd_hdr_wr_addr + HDR_ADDR_WIDTH'(STRB_WIDTH);
          w_cnt               <= w_cnt - CW'(1);
          if (s_axis_tlast) begin
            // a packet shorter than the request still completes, flagged as an error
            wr_done      <= 1'b1;
            wr_err       <= !w_final;
            wr_req_ready <= 1'b1;
            w_state      <= W_IDLE;
          end else if (w_final) begin
            wr_err  <= 1'b1;
            w_state <= W_DRAIN;
          end
        end
        W_DRAIN: if (s_axis_tvalid && s_axis_tlast) begin
          wr_req_ready <= 1'b1;
          w_state      <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // ---------------- read path ----------------
  r_state_t                  r_state;
  logic [CW-1:0]             r_n, r_issued, r_recv;
  logic [BL-1:0]             r_lo;
  logic                      r_active, r_resp_final, r_resp_hs;

  assign r_active          = (r_state == R_CMD) || (r_state == R_RESP);
  assign r_resp_final      = (r_recv == r_n - CW'(1));
  assign dma_cmd_rd_last   = dma_cmd_rd_en && (r_issued == r_n - CW'(1));
  assign m_axis_tvalid     = r_active && dma_rd_resp_valid;
  assign dma_rd_resp_ready = r_active && m_axis_tready;
  assign m_axis_tdata      = dma_rd_resp_data;
  assign m_axis_tkeep      = r_resp_final ? final_mask(r_lo) : '1;
  assign m_axis_tlast      = r_active && r_resp_final;
  assign r_resp_hs         = m_axis_tvalid && m_axis_tready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state         <= R_IDLE;
      rd_req_ready    <= 1'b0;
      dma_cmd_rd_en   <= 1'b0;
      dma_cmd_rd_addr <= '0;
      r_n             <= '0;
      r_issued        <= '0;
      r_recv          <= '0;
      r_lo            <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          rd_req_ready <= 1'b1;
          if (rd_req_valid && rd_req_ready && rd_req_len != '0) begin
            dma_cmd_rd_addr <= rd_req_addr;
            r_n             <= beats(rd_req_len);
            r_lo            <= rd_req_len[BL-1:0];
            r_issued        <= '0;
            r_recv          <= '0;
            dma_cmd_rd_en   <= 1'b1;
            rd_req_ready    <= 1'b0;
            r_state         <= R_CMD;
          end
        end
        R_CMD, R_RESP: begin
          if (dma_cmd_rd_en && dma_cmd_rd_ready) begin
            dma_cmd_rd_addr <= dma_cmd_rd_addr + ADDR_WIDTH'(STRB_WIDTH);
            r_issued        <= r_issued + CW'(1);
            if (dma_cmd_rd_last) begin
              dma_cmd_rd_en <= 1'b0;
              r_state       <= R_RESP;
            end
          end
          // final response ends the request; placed last so it wins over the command branch
          if (r_resp_hs) begin
            r_recv <= r_recv + CW'(1);
            if (r_resp_final) begin
              dma_cmd_rd_en <= 1'b0;
              rd_req_ready  <= 1'b1;
              r_state       <= R_IDLE;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_core_dma_cmd_master.sv
// Directed bench for core_dma_cmd_master: write bursts, header writes, length
// mismatches, randomly stalled reads, mid-burst reset and zero-length requests.
module tb_core_dma_cmd_master;
  logic         clk = 1'b0;
  logic         rst_n;
  logic [25:0]  wr_req_addr;
  logic [23:0]  wr_req_hdr_addr;
  logic         wr_req_hdr_en;
  logic [15:0]  wr_req_len;
  logic         wr_req_valid, wr_req_ready;
  logic [127:0] s_axis_tdata;
  logic [15:0]  s_axis_tkeep;
  logic         s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic         dma_cmd_wr_en;
  logic [25:0]  dma_cmd_wr_addr;
  logic         dma_cmd_hdr_wr_en;
  logic [23:0]  dma_cmd_hdr_wr_addr;
  logic [127:0] dma_cmd_wr_data;
  logic [15:0]  dma_cmd_wr_strb;
  logic         dma_cmd_wr_last, dma_cmd_wr_ready;
  logic [25:0]  rd_req_addr;
  logic [15:0]  rd_req_len;
  logic         rd_req_valid, rd_req_ready;
  logic         dma_cmd_rd_en;
  logic [25:0]  dma_cmd_rd_addr;
  logic         dma_cmd_rd_last, dma_cmd_rd_ready;
  logic         dma_rd_resp_valid;
  logic [127:0] dma_rd_resp_data;
  logic         dma_rd_resp_ready;
  logic [127:0] m_axis_tdata;
  logic [15:0]  m_axis_tkeep;
  logic         m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic         wr_done, wr_err;

  int n_checks = 0;
  int n_errs   = 0;
  logic [127:0] rq[$];

  core_dma_cmd_master #(.DATA_WIDTH(128), .ADDR_WIDTH(26), .HDR_ADDR_WIDTH(24), .LEN_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_req_addr(wr_req_addr), .wr_req_hdr_addr(wr_req_hdr_addr), .wr_req_hdr_en(wr_req_hdr_en),
    .wr_req_len(wr_req_len), .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .dma_cmd_wr_en(dma_cmd_wr_en), .dma_cmd_wr_addr(dma_cmd_wr_addr),
    .dma_cmd_hdr_wr_en(dma_cmd_hdr_wr_en), .dma_cmd_hdr_wr_addr(dma_cmd_hdr_wr_addr),
    .dma_cmd_wr_data(dma_cmd_wr_data), .dma_cmd_wr_strb(dma_cmd_wr_strb),
    .dma_cmd_wr_last(dma_cmd_wr_last), .dma_cmd_wr_ready(dma_cmd_wr_ready),
    .rd_req_addr(rd_req_addr), .rd_req_len(rd_req_len), .rd_req_valid(rd_req_valid),
    .rd_req_ready(rd_req_ready), .dma_cmd_rd_en(dma_cmd_rd_en), .dma_cmd_rd_addr(dma_cmd_rd_addr),
    .dma_cmd_rd_last(dma_cmd_rd_last), .dma_cmd_rd_ready(dma_cmd_rd_ready),
    .dma_rd_resp_valid(dma_rd_resp_valid), .dma_rd_resp_data(dma_rd_resp_data),
    .dma_rd_resp_ready(dma_rd_resp_ready), .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .wr_done(wr_done), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [127:0] pat(input int i);
    pat = {4{32'hC0DE0000 + 32'(i)}};
  endfunction

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic wr_req(input logic [25:0] a, input logic [23:0] ha, input logic he, input logic [15:0] len);
    int t = 0;
    wr_req_addr = a; wr_req_hdr_addr = ha; wr_req_hdr_en = he; wr_req_len = len; wr_req_valid = 1'b1;
    @(negedge clk);
    while (!wr_req_ready && t < 20) begin @(negedge clk); t++; end
    check("wr_req_ready", 128'(wr_req_ready), 128'(1));
    next_cycle();
    wr_req_valid = 1'b0;
  endtask

  task automatic rd_req(input logic [25:0] a, input logic [15:0] len);
    int t = 0;
    rd_req_addr = a; rd_req_len = len; rd_req_valid = 1'b1;
    @(negedge clk);
    while (!rd_req_ready && t < 20) begin @(negedge clk); t++; end
    check("rd_req_ready", 128'(rd_req_ready), 128'(1));
    next_cycle();
    rd_req_valid = 1'b0;
  endtask

  task automatic wr_beat(input logic [127:0] d, input logic [15:0] keep, input logic tl,
                         input logic [25:0] ea, input logic [15:0] es, input logic el,
                         input logic eh, input logic [23:0] eha);
    s_axis_tvalid = 1'b1; s_axis_tdata = d; s_axis_tkeep = keep; s_axis_tlast = tl; dma_cmd_wr_ready = 1'b1;
    @(negedge clk);
    check("wr_en",    128'(dma_cmd_wr_en), 128'(1));
    check("s_tready", 128'(s_axis_tready), 128'(1));
    check("wr_addr",  128'(dma_cmd_wr_addr), 128'(ea));
    check("wr_data",  dma_cmd_wr_data, d);
    check("wr_strb",  128'(dma_cmd_wr_strb), 128'(es));
    check("wr_last",  128'(dma_cmd_wr_last), 128'(el));
    check("hdr_en",   128'(dma_cmd_hdr_wr_en), 128'(eh));
    if (eh) check("hdr_addr", 128'(dma_cmd_hdr_wr_addr), 128'(eha));
    next_cycle();
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
  endtask

  task automatic check_done(input logic ed, input logic ee);
    @(negedge clk);
    check("wr_done", 128'(wr_done), 128'(ed));
    check("wr_err",  128'(wr_err),  128'(ee));
    next_cycle();
  endtask

  // core model answers each accepted read command with pat(index), one or more cycles later
  task automatic rd_run(input logic [25:0] base, input logic [15:0] len, input int n, input logic [15:0] kmask);
    int ncmd = 0;
    int nresp = 0;
    rq.delete();
    rd_req(base, len);
    for (int cyc = 0; cyc < 200 && nresp < n; cyc++) begin
      dma_cmd_rd_ready  = 1'($urandom_range(0, 1));
      m_axis_tready     = 1'($urandom_range(0, 1));
      dma_rd_resp_valid = (rq.size() > 0);
      dma_rd_resp_data  = (rq.size() > 0) ? rq[0] : '0;
      @(negedge clk);
      if (dma_cmd_rd_en && dma_cmd_rd_ready) begin
        check("rd_addr", 128'(dma_cmd_rd_addr), 128'(base + 26'(16 * ncmd)));
        check("rd_last", 128'(dma_cmd_rd_last), 128'(ncmd == n - 1));
        rq.push_back(pat(ncmd));
        ncmd++;
      end
      if (m_axis_tvalid && m_axis_tready) begin
        check("m_tdata", m_axis_tdata, pat(nresp));
        check("m_tkeep", 128'(m_axis_tkeep), 128'((nresp == n - 1) ? kmask : 16'hFFFF));
        check("m_tlast", 128'(m_axis_tlast), 128'(nresp == n - 1));
        void'(rq.pop_front());
        nresp++;
      end
      next_cycle();
    end
    check("rd_resp_count", 128'(nresp), 128'(n));
    check("rd_cmd_count",  128'(ncmd),  128'(n));
    dma_cmd_rd_ready = 1'b0; m_axis_tready = 1'b0; dma_rd_resp_valid = 1'b0;
    @(negedge clk);
    check("rd_idle_ready", 128'(rd_req_ready), 128'(1));
    check("rd_idle_en",    128'(dma_cmd_rd_en), 128'(0));
    next_cycle();
  endtask

  initial begin
    rst_n = 1'b0;
    wr_req_addr = '0; wr_req_hdr_addr = '0; wr_req_hdr_en = 1'b0; wr_req_len = '0; wr_req_valid = 1'b0;
    s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; dma_cmd_wr_ready = 1'b0;
    rd_req_addr = '0; rd_req_len = '0; rd_req_valid = 1'b0; dma_cmd_rd_ready = 1'b0;
    dma_rd_resp_valid = 1'b0; dma_rd_resp_data = '0; m_axis_tready = 1'b0;
    repeat (3) next_cycle();
    @(negedge clk);
    check("rst_wr_req_ready", 128'(wr_req_ready), 128'(0));
    check("rst_rd_req_ready", 128'(rd_req_ready), 128'(0));
    check("rst_wr_en",        128'(dma_cmd_wr_en), 128'(0));
    check("rst_rd_en",        128'(dma_cmd_rd_en), 128'(0));
    check("rst_wr_done",      128'(wr_done), 128'(0));
    check("rst_m_tvalid",     128'(m_axis_tvalid), 128'(0));
    next_cycle();
    rst_n = 1'b1;

    // 64B write, one core stall before beat 2
    wr_req(26'h1000, 24'h0, 1'b0, 16'd64);
    wr_beat(pat(100), 16'hFFFF, 1'b0, 26'h1000, 16'hFFFF, 1'b0, 1'b0, 24'h0);
    s_axis_tvalid = 1'b1; s_axis_tdata = pat(101); s_axis_tkeep = 16'hFFFF; dma_cmd_wr_ready = 1'b0;
    @(negedge clk);
    check("stall_tready", 128'(s_axis_tready), 128'(0));
    check("stall_addr",   128'(dma_cmd_wr_addr), 128'(26'h1010));
    next_cycle();
    wr_beat(pat(101), 16'hFFFF, 1'b0, 26'h1010, 16'hFFFF, 1'b0, 1'b0, 24'h0);
    wr_beat(pat(102), 16'hFFFF, 1'b0, 26'h1020, 16'hFFFF, 1'b0, 1'b0, 24'h0);
    wr_beat(pat(103), 16'hFFFF, 1'b1, 26'h1030, 16'hFFFF, 1'b1, 1'b0, 24'h0);
    check_done(1'b1, 1'b0);

    // 20B write with header, partial final beat
    wr_req(26'h2000, 24'h200, 1'b1, 16'd20);
    wr_beat(pat(200), 16'hFFFF, 1'b0, 26'h2000, 16'hFFFF, 1'b0, 1'b1, 24'h200);
    wr_beat(pat(201), 16'hFFFF, 1'b1, 26'h2010, 16'h000F, 1'b1, 1'b1, 24'h210);
    check_done(1'b1, 1'b0);

    // 48B request, packet ends after 2 beats
    wr_req(26'h3000, 24'h0, 1'b0, 16'd48);
    wr_beat(pat(300), 16'hFFFF, 1'b0, 26'h3000, 16'hFFFF, 1'b0, 1'b0, 24'h0);
    wr_beat(pat(301), 16'hFFFF, 1'b1, 26'h3010, 16'hFFFF, 1'b1, 1'b0, 24'h0);
    check_done(1'b1, 1'b1);

    // 16B request, 3-beat packet: one beat written, two drained
    wr_req(26'h3800, 24'h0, 1'b0, 16'd16);
    wr_beat(pat(400), 16'hFFFF, 1'b0, 26'h3800, 16'hFFFF, 1'b1, 1'b0, 24'h0);
    @(negedge clk);
    check("len_err", 128'(wr_err), 128'(1));
    for (int i = 0; i < 2; i++) begin
      s_axis_tvalid = 1'b1; s_axis_tlast = (i == 1); s_axis_tdata = pat(401 + i);
      @(negedge clk);
      check("drain_tready", 128'(s_axis_tready), 128'(1));
      check("drain_wr_en",  128'(dma_cmd_wr_en), 128'(0));
      next_cycle();
    end
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    @(negedge clk);
    check("drain_idle", 128'(wr_req_ready), 128'(1));
    next_cycle();

    // 40B read with random stalls
    rd_run(26'h40, 16'd40, 3, 16'h00FF);

    // simultaneous requests, then reset mid-burst
    wr_req_addr = 26'h5000; wr_req_len = 16'd64; wr_req_hdr_en = 1'b0; wr_req_valid = 1'b1;
    rd_req_addr = 26'h80; rd_req_len = 16'd64; rd_req_valid = 1'b1;
    @(negedge clk);
    check("both_wr_ready", 128'(wr_req_ready), 128'(1));
    check("both_rd_ready", 128'(rd_req_ready), 128'(1));
    next_cycle();
    wr_req_valid = 1'b0; rd_req_valid = 1'b0;
    wr_beat(pat(500), 16'hFFFF, 1'b0, 26'h5000, 16'hFFFF, 1'b0, 1'b0, 24'h0);
    s_axis_tvalid = 1'b1; s_axis_tdata = pat(501); dma_cmd_wr_ready = 1'b1;
    dma_rd_resp_valid = 1'b1; m_axis_tready = 1'b1;
    @(negedge clk);
    check("pre_rst_rd_en", 128'(dma_cmd_rd_en), 128'(1));
    rst_n = 1'b0;
    next_cycle();
    @(negedge clk);
    check("mid_rst_wr_en",   128'(dma_cmd_wr_en), 128'(0));
    check("mid_rst_wr_last", 128'(dma_cmd_wr_last), 128'(0));
    check("mid_rst_tready",  128'(s_axis_tready), 128'(0));
    check("mid_rst_rd_en",   128'(dma_cmd_rd_en), 128'(0));
    check("mid_rst_rd_addr", 128'(dma_cmd_rd_addr), 128'(0));
    check("mid_rst_m_valid", 128'(m_axis_tvalid), 128'(0));
    check("mid_rst_wr_rdy",  128'(wr_req_ready), 128'(0));
    next_cycle();
    rst_n = 1'b1; s_axis_tvalid = 1'b0; dma_rd_resp_valid = 1'b0; m_axis_tready = 1'b0;
    wr_req(26'h6000, 24'h0, 1'b0, 16'd16);
    wr_beat(pat(600), 16'hFFFF, 1'b1, 26'h6000, 16'hFFFF, 1'b1, 1'b0, 24'h0);
    check_done(1'b1, 1'b0);
    rd_run(26'h100, 16'd16, 1, 16'hFFFF);

    // zero-length write and read
    s_axis_tvalid = 1'b1; s_axis_tdata = pat(700);
    wr_req(26'h7000, 24'h0, 1'b0, 16'd0);
    @(negedge clk);
    check("len0_done",   128'(wr_done), 128'(1));
    check("len0_wr_en",  128'(dma_cmd_wr_en), 128'(0));
    check("len0_tready", 128'(s_axis_tready), 128'(0));
    next_cycle();
    s_axis_tvalid = 1'b0;
    dma_rd_resp_valid = 1'b1; m_axis_tready = 1'b1;
    rd_req(26'h7000, 16'd0);
    @(negedge clk);
    check("len0_rd_en",      128'(dma_cmd_rd_en), 128'(0));
    check("len0_rd_ready",   128'(rd_req_ready), 128'(1));
    check("len0_resp_ready", 128'(dma_rd_resp_ready), 128'(0));
    check("len0_no_done",    128'(wr_done), 128'(0));
    next_cycle();
    dma_rd_resp_valid = 1'b0; m_axis_tready = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
